// File: rtl/cnt_timer_arbiter_pkg.sv
// rtl/cnt_timer_arbiter_pkg.sv - shared state type and default sizing for the counter arbiter
package cnt_timer_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/cnt_timer_arbiter_ld_upcounter.sv
// rtl/cnt_timer_arbiter_ld_upcounter.sv - loadable CW-bit up-counter with terminal-count flag
module ld_upcounter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] q,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

  assign tc = &q;

endmodule

// File: rtl/cnt_timer_arbiter.sv
// rtl/cnt_timer_arbiter.sv - round-robin sharing of one up-counter among NREQ timed requesters
// Optional: CNT_ARB_ABORT_EN lets the owner cancel its interval by dropping req during RUN.
module cnt_timer_arbiter
  import cnt_timer_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   start_val,
  input  logic                 hold,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic [NREQ-1:0]      done,
  output logic [CW-1:0]        count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state, state_nxt;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win_idx;
  logic          any_req;
  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_tc;
  logic          abort;

  // Search starts just after the previous owner so every requester gets a turn.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx  = (int'(last) + i) % NREQ;
      cand = idx[IW-1:0];
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_req = |req;
  assign win_idx = rr_pick(req, last_grant);

`ifdef CNT_ARB_ABORT_EN
  assign abort = (state == RUN) && !req[last_grant];
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN: begin
        if (abort)                state_nxt = IDLE;
        else if (!hold && cnt_tc) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    cnt_load = (state == LOAD);
    cnt_en   = (state == RUN) && !hold && !cnt_tc && !abort;
  end

  // last_grant doubles as the current owner index while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      done       <= '0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= NREQ'(1) << win_idx;
            last_grant <= win_idx;
          end
        end
        RUN: begin
          if (abort) grant <= '0;
        end
        FIN: begin
          done  <= grant;
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

  ld_upcounter #(.CW(CW)) u_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .din  (start_val[int'(last_grant)*CW +: CW]),
    .q    (count),
    .tc   (cnt_tc)
  );

endmodule

// File: tb/tb_cnt_timer_arbiter.sv
// tb/tb_cnt_timer_arbiter.sv - directed and randomized checks of cnt_timer_arbiter against a transaction model
module tb_cnt_timer_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*CW-1:0]  start_val;
  logic                hold;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic [NREQ-1:0]     done;
  logic [CW-1:0]       count;

  int n_checks = 0;
  int n_pass   = 0;
  bit auto_drop = 1'b1;

  // transaction-level reference: owner, loaded value, advancing steps left
  bit              m_active;
  int              m_phase;
  int              m_owner;
  int              m_last;
  int              m_steps;
  int              m_cnt;
  logic [NREQ-1:0] m_grant;
  logic [NREQ-1:0] m_done;
  logic            m_busy;

  cnt_timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .start_val (start_val),
    .hold      (hold),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic model_step();
    bit ab;
    if (rst) begin
      m_active = 0; m_last = NREQ - 1; m_grant = '0; m_done = '0; m_busy = 0; m_cnt = 0;
      return;
    end
    m_done = '0;
    if (!m_active) begin
      if (req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (req[c]) begin m_owner = c; break; end
        end
        m_last = m_owner; m_active = 1; m_phase = 0; m_busy = 1;
        m_grant = '0; m_grant[m_owner] = 1'b1;
      end
    end else begin
      case (m_phase)
        0: begin
          m_cnt   = int'(start_val[m_owner*CW +: CW]);
          m_steps = MAXV - m_cnt + 1;
          m_phase = 1;
        end
        1: begin
          ab = 0;
`ifdef CNT_ARB_ABORT_EN
          ab = !req[m_owner];
`endif
          if (ab) begin
            m_active = 0; m_grant = '0; m_busy = 0;
          end else if (!hold) begin
            m_steps--;
            if (m_steps == 0) m_phase = 2;
            else m_cnt = MAXV + 1 - m_steps;
          end
        end
        default: begin
          m_done = m_grant; m_grant = '0; m_busy = 0; m_active = 0;
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("grant", grant, m_grant);
    check("done", done, m_done);
    check("busy", busy, m_busy);
    check("count", count, m_cnt);
    if (auto_drop)
      for (int i = 0; i < NREQ; i++) if (m_done[i]) req[i] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (req == '0 && !m_active) break;
      cycle();
    end
    if (req != '0 || m_active) begin
      n_checks++;
      $display("FAIL drain_timeout got=busy exp=idle within 100 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int exp_order[5];
    int got_order[5];
    int ng;
    logic [NREQ-1:0] prev_g;

    req = '0; start_val = '0; hold = 1'b0; rst = 1'b0;
    m_active = 0; m_last = NREQ - 1; m_grant = '0; m_done = '0; m_busy = 0; m_cnt = 0;
    #2;
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);

    // single request from requester 0
    start_val[0 +: CW] = 4'd12; req = 4'b0001;
    cycle(); check("s_grant", grant, 4'b0001); check("s_busy", busy, 1);
    cycle(); check("s_cnt_e1", count, 12);
    cycle(); check("s_cnt_e2", count, 13);
    cycle(); check("s_cnt_e3", count, 14);
    cycle(); check("s_cnt_e4", count, 15);
    cycle(); check("s_done_e5", done, 0);
    cycle(); check("s_done_e6", done, 4'b0001); check("s_grant_clr", grant, 0);
    cycle(); check("s_busy_e7", busy, 0);

    // start at MAX: one RUN cycle
    start_val[2*CW +: CW] = 4'd15; req = 4'b0100;
    cycle(); check("b_grant", grant, 4'b0100);
    cycle(); check("b_cnt", count, 15);
    cycle(); check("b_done_e2", done, 0);
    cycle(); check("b_done_e3", done, 4'b0100);
    cycle();

    // hold freezes the count for three cycles
    start_val[CW +: CW] = 4'd13; req = 4'b0010;
    cycle(); check("h_grant", grant, 4'b0010);
    cycle(); check("h_cnt", count, 13);
    hold = 1'b1;
    repeat (3) begin cycle(); check("h_frozen", count, 13); end
    hold = 1'b0;
    cycle(); check("h_cnt14", count, 14);
    cycle(); check("h_cnt15", count, 15);
    cycle(); check("h_done_early", done, 0);
    cycle(); check("h_done", done, 4'b0010);
    cycle();

    // reset in the middle of RUN
    start_val[0 +: CW] = 4'd5; req = 4'b0001;
    repeat (6) cycle();
    check("r_cnt9", count, 9);
    do_reset();
    check("r_grant", grant, 0); check("r_count", count, 0);
    check("r_busy", busy, 0);   check("r_done", done, 0);
    start_val[2*CW +: CW] = 4'd11; req = 4'b0100;
    cycle(); check("r_next_grant", grant, 4'b0100);
    drain();

    // fairness with all requests held
    do_reset();
    auto_drop = 1'b0;
    for (int i = 0; i < NREQ; i++) start_val[i*CW +: CW] = 4'd14;
    req = 4'b1111;
    exp_order = '{0, 1, 2, 3, 0};
    ng = 0; prev_g = '0;
    for (int n = 0; n < 200 && ng < 5; n++) begin
      cycle();
      if (grant != '0 && prev_g == '0) begin
        for (int i = 0; i < NREQ; i++) if (grant[i]) got_order[ng] = i;
        ng++;
      end
      prev_g = grant;
    end
    check("f_ngrants", ng, 5);
    for (int k = 0; k < ng && k < 5; k++) check("f_order", got_order[k], exp_order[k]);
    auto_drop = 1'b1;
`ifdef CNT_ARB_ABORT_EN
    drain();
`else
    req = '0;
    drain();
`endif

`ifdef CNT_ARB_ABORT_EN
    // owner 3 abandons its interval at count 5
    do_reset();
    start_val[3*CW +: CW] = 4'd2; req = 4'b1000;
    cycle(); check("a_grant", grant, 4'b1000);
    start_val[CW +: CW] = 4'd14; req[1] = 1'b1;
    repeat (4) cycle();
    check("a_cnt5", count, 5);
    req[3] = 1'b0;
    cycle();
    check("a_grant_clr", grant, 0); check("a_done", done, 0);
    check("a_count_hold", count, 5); check("a_busy", busy, 0);
    cycle(); check("a_next_grant", grant, 4'b0010);
    drain();
`endif

    // randomized traffic with hold and occasional reset
    for (int n = 0; n < 3000; n++) begin
      cycle();
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          start_val[i*CW +: CW] = CW'($urandom_range(0, MAXV));
          req[i] = 1'b1;
        end
      hold = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; hold = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnt_timer_arbiter.md
# cnt_timer_arbiter

Shares one loadable up-counter between NREQ requesters, each wanting a timed interval. Grants requesters round-robin, loads the counter with the winner's start value, and runs it to terminal count. Pulses a per-requester done. Sits between the counter datapath and the blocks that need delays or timeouts.

## Interface
- NREQ, 4, number of requesters (2..8)
- CW, 4, counter width; terminal value MAX = 2^CW-1
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- req  in  NREQ  per-requester request level; held high until its done
- start_val  in  NREQ*CW  packed start values; requester i at bits [i*CW +: CW]
- hold  in  1  freezes counting while high (RUN only)
- grant  out  NREQ  one-hot owner of the counter; all-zero when idle
- busy  out  1  high in every state except IDLE
- done  out  NREQ  one-cycle pulse to the owner at completion
- count  out  CW  live counter value

## Operation
- FSM states: IDLE, LOAD, RUN, FIN.
- **IDLE**
  - If any req is high, pick a winner round-robin: search from last_grant+1 mod NREQ upward.
  - Register the winner into grant and last_grant, then go to LOAD.
  - If no req is high, stay in IDLE.
- **LOAD:** count <= start_val[winner], then go to RUN.
- **RUN**
  - If hold is high, count and state are frozen.
  - Else if count == MAX, go to FIN; count stays at MAX and never wraps.
  - Else count <= count+1.
- **FIN:** done[winner]=1 for this cycle only, then go to IDLE; grant clears on that edge.
- Arithmetic: unsigned, CW bits; the terminal compare is against all-ones.
- Requests arriving while busy are not lost. They are arbitrated at the next IDLE.
- A requester dropping req outside RUN has no effect on the current transaction.
- Reset, at any state including mid-RUN:
  - state=IDLE, grant=0, busy=0, done=0, count=0.
  - last_grant=NREQ-1, so requester 0 wins first.
  - No done is emitted for the interrupted transaction.

## Timing
- Cycle numbering: edge e0 samples req in IDLE.
  - After e0: grant valid, busy=1.
  - After e1: count=start_val.
- RUN lasts MAX-start_val+1 cycles plus the number of hold cycles.
- done is high for the cycle after FIN is entered.
- Total latency from sampling edge to done asserted: MAX-start_val+3 cycles with no hold.
- Back-to-back: FIN -> IDLE -> LOAD. Minimum gap between transactions is one IDLE cycle.
- done and grant are both registered outputs. busy is decoded from the state register.

## Configuration
- CNT_ARB_ABORT_EN
  - **Defined:** req[winner] low while in RUN aborts the transaction. Go to IDLE next edge, grant clears, no done pulse, count holds its value. hold does not block abort.
  - **Undefined:** req is ignored after arbitration. The transaction always runs to FIN.

## Structure
- Package cnt_timer_arbiter_pkg holds:
  - The state enum typedef (IDLE, LOAD, RUN, FIN).
  - The default NREQ and CW constants.
- Sub-module ld_upcounter holds the loadable up-counter (CW-bit datapath).
  - Inputs: clk, rst, load, en, din.
  - Outputs: q, tc (q==MAX).
  - The FSM drives load in LOAD and en in RUN when hold is low and tc is low.
- Round-robin selection is a combinational function in the arbiter top.

## Test plan
- Single request: req=4'b0001, start_val[0]=12 -> grant=0001 after e0, count 12,13,14,15, done[0] pulse after e6, busy drops after e7.
- Boundary start: req[2]=1, start_val=15 -> exactly one RUN cycle, done[2] after e3.
- Fairness: req=4'b1111 held, all start_val=14 -> grants in order 0,1,2,3,0 and each done matches its grant.
- Hold: requester 1 at start_val=13, hold high for 3 cycles mid-RUN -> count frozen during hold, done delayed by exactly 3 cycles.
- Reset mid-RUN: rst at count=9 -> next cycle grant=0, count=0, busy=0, no done pulse; with req=4'b0100, next grant goes to requester 2.
- Abort (CNT_ARB_ABORT_EN defined): requester 3 drops req at count=5 -> IDLE next edge, no done[3], next pending requester granted.
